// File: rtl/ntt_addsub_stage.sv
// ntt_addsub_stage
// ----------------
// Final stage of the NTT/INTT butterfly. The shared multiply/reduce unit
// produces the reduced product prod = v*w. This stage delays the other
// operand u so that it meets that product, then registers the modular sum
// u+prod and difference u-prod. It can optionally multiply both results by
// 2^-1 mod q, which the inverse transform uses for its final scaling.
//
// Arithmetic modes (chosen per operation and carried along with u):
//   mode = 0 : Kyber, two independent 12-bit lanes {hi[23:12], lo[11:0]}, q = 3329
//   mode = 1 : Dilithium, one 23-bit lane in [22:0], q = 8380417, bit 23 ignored/zero
//
// Parameters:
//   MUL_LAT  cycles from operands entering the multiplier to prod being valid (1..8)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   u/mode/half_en valid (same cycle the multiplier takes its operands)
//   u          butterfly operand u, packed per mode
//   mode       0 = Kyber, 1 = Dilithium
//   half_en    1 = halve both results modulo q
//   prod       reduced product, sampled only in the aligned cycle
//   out_valid  out_add/out_sub hold a new result
//   out_add    (u + prod) mod q per lane, optionally halved
//   out_sub    (u - prod) mod q per lane, optionally halved
module ntt_addsub_stage #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] u,
  input  logic        mode,
  input  logic        half_en,
  input  logic [23:0] prod,
  output logic        out_valid,
  output logic [23:0] out_add,
  output logic [23:0] out_sub
);

  localparam logic [12:0] KQ = 13'd3329;
  localparam logic [23:0] DQ = 24'd8380417;

  // One alignment slot: the operation's control travels with its data so
  // back-to-back operations of different modes never get mixed up.
  typedef struct packed {
    logic        valid;
    logic        mode;
    logic        half;
    logic [23:0] u;
  } slot_t;

  slot_t pipe [MUL_LAT];
  slot_t tap;

  logic [23:0] next_add;
  logic [23:0] next_sub;

  // ---------------- Kyber lane helpers (12-bit, q = 3329) ----------------
  function automatic logic [11:0] k_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= KQ) s = s - KQ;
    return s[11:0];
  endfunction

  // The 13-bit difference of two values < 4096 has bit 12 set exactly when
  // it went negative, so that bit is the borrow.
  function automatic logic [11:0] k_sub(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[12]) d = d + KQ;
    return d[11:0];
  endfunction

  // Halving modulo an odd q: an odd x becomes even after adding q, so the
  // shift is exact and the result stays below q.
  function automatic logic [11:0] k_half(input logic [11:0] x, input logic en);
    logic [12:0] t;
    t = {1'b0, x};
    if (en && x[0]) t = t + KQ;
    if (en) return t[12:1];
    else return x;
  endfunction

  // ------------- Dilithium lane helpers (23-bit, q = 8380417) -------------
  function automatic logic [22:0] d_add(input logic [22:0] a, input logic [22:0] b);
    logic [23:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DQ) s = s - DQ;
    return s[22:0];
  endfunction

  function automatic logic [22:0] d_sub(input logic [22:0] a, input logic [22:0] b);
    logic [23:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[23]) d = d + DQ;
    return d[22:0];
  endfunction

  function automatic logic [22:0] d_half(input logic [22:0] x, input logic en);
    logic [23:0] t;
    t = {1'b0, x};
    if (en && x[0]) t = t + DQ;
    if (en) return t[23:1];
    else return x;
  endfunction

  // Alignment shift register: entry 0 captures the new operation, the last
  // entry lines up with the multiplier's result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: in_valid, mode: mode, half: half_en, u: u};
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tap = pipe[MUL_LAT-1];

  // Add/sub with conditional correction, then optional halving. Kyber lanes
  // are computed separately so no carry or borrow crosses bit 12.
  always_comb begin
    next_add = '0;
    next_sub = '0;
    if (tap.mode) begin
      next_add = {1'b0, d_half(d_add(tap.u[22:0], prod[22:0]), tap.half)};
      next_sub = {1'b0, d_half(d_sub(tap.u[22:0], prod[22:0]), tap.half)};
    end else begin
      next_add = {k_half(k_add(tap.u[23:12], prod[23:12]), tap.half),
                  k_half(k_add(tap.u[11:0],  prod[11:0]),  tap.half)};
      next_sub = {k_half(k_sub(tap.u[23:12], prod[23:12]), tap.half),
                  k_half(k_sub(tap.u[11:0],  prod[11:0]),  tap.half)};
    end
  end

  // Result registers load only for a valid aligned slot; otherwise the data
  // holds and only out_valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_add   <= '0;
      out_sub   <= '0;
    end else begin
      out_valid <= tap.valid;
      if (tap.valid) begin
        out_add <= next_add;
        out_sub <= next_sub;
      end
    end
  end

endmodule

// File: tb/tb_ntt_addsub_stage.sv
// tb_ntt_addsub_stage
// -------------------
// Bench for ntt_addsub_stage. A driver process logs every cycle's inputs
// (operation, product, reset level) into per-cycle tables. A separate
// checker process rebuilds the expected output registers each cycle from
// those tables using plain modular arithmetic, and compares them with the DUT.
// Directed operations also carry hand-computed literal results.
module tb_ntt_addsub_stage;

  localparam int LAT  = 4;
  localparam int NCYC = 512;
  localparam longint QK = 3329;
  localparam longint QD = 8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [23:0] u;
  logic        mode;
  logic        half_en;
  logic [23:0] prod;
  logic        out_valid;
  logic [23:0] out_add;
  logic [23:0] out_sub;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Per-cycle stimulus log, indexed by the cycle in which the input was driven.
  bit          rst_low [NCYC];
  bit          op_v    [NCYC];
  bit          op_m    [NCYC];
  bit          op_h    [NCYC];
  logic [23:0] op_u    [NCYC];
  logic [23:0] op_p    [NCYC];
  bit          lit_v   [NCYC];
  logic [23:0] lit_a   [NCYC];
  logic [23:0] lit_s   [NCYC];

  // Expected state of the DUT output registers.
  bit          m_valid = 1'b0;
  logic [23:0] m_add   = '0;
  logic [23:0] m_sub   = '0;
  int          last_rst = -1;

  ntt_addsub_stage #(.MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .u         (u),
    .mode      (mode),
    .half_en   (half_en),
    .prod      (prod),
    .out_valid (out_valid),
    .out_add   (out_add),
    .out_sub   (out_sub)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference arithmetic on one lane: plain modular sum/difference, and
  // halving as multiplication by the inverse of 2.
  function automatic longint lane(longint x, longint y, longint q, bit sub, bit h);
    longint r;
    r = sub ? (x - y + q) % q : (x + y) % q;
    if (h) r = (r * ((q + 1) / 2)) % q;
    return r;
  endfunction

  function automatic logic [23:0] ref_op(bit m, bit h, bit sub, logic [23:0] a, logic [23:0] b);
    logic [23:0] res;
    longint r, rh, rl;
    if (m) begin
      r   = lane(longint'(a[22:0]), longint'(b[22:0]), QD, sub, h);
      res = {1'b0, r[22:0]};
    end else begin
      rh  = lane(longint'(a[23:12]), longint'(b[23:12]), QK, sub, h);
      rl  = lane(longint'(a[11:0]),  longint'(b[11:0]),  QK, sub, h);
      res = {rh[11:0], rl[11:0]};
    end
    return res;
  endfunction

  task automatic cmp(string name, logic [23:0] got, logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, got, exp);
    end
  endtask

  // Rebuild the expected registers for the edge just taken, then compare.
  task automatic checkOutput();
    int e, pc, t;
    e  = edge_cnt;
    pc = e - 1;
    if (pc < 0 || pc >= NCYC) return;
    if (rst_low[pc]) begin
      m_valid  = 1'b0;
      m_add    = '0;
      m_sub    = '0;
      last_rst = pc;
    end else begin
      t = pc - LAT;
      if (t >= 0 && op_v[t] && t > last_rst) begin
        m_valid = 1'b1;
        m_add   = ref_op(op_m[t], op_h[t], 1'b0, op_u[t], op_p[t]);
        m_sub   = ref_op(op_m[t], op_h[t], 1'b1, op_u[t], op_p[t]);
        if (lit_v[t]) begin
          cmp("literal_add", out_add, lit_a[t]);
          cmp("literal_sub", out_sub, lit_s[t]);
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    cmp("out_valid", {23'b0, out_valid}, {23'b0, m_valid});
    cmp("out_add",   out_add, m_add);
    cmp("out_sub",   out_sub, m_sub);
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput();
  end

  // Drive one cycle. The product for the operation issued LAT cycles ago is
  // presented now; in every other cycle prod carries noise.
  task automatic applyStimulus(bit rl, bit v, bit m, bit h, logic [23:0] uu, logic [23:0] pp,
                               bit lv, logic [23:0] la, logic [23:0] ls);
    int c;
    @(posedge clk);
    #2;
    c        = edge_cnt;
    rst      = !rl;
    in_valid = v;
    mode     = m;
    half_en  = h;
    u        = uu;
    if (c < NCYC) begin
      rst_low[c] = rl;
      op_v[c]    = v;
      op_m[c]    = m;
      op_h[c]    = h;
      op_u[c]    = uu;
      op_p[c]    = pp;
      lit_v[c]   = lv;
      lit_a[c]   = la;
      lit_s[c]   = ls;
    end
    if (c >= LAT && c - LAT < NCYC && op_v[c-LAT]) prod = op_p[c-LAT];
    else prod = 24'($urandom);
    if (rl) begin
      #1;
      cmp("reset_valid", {23'b0, out_valid}, 24'h0);
      cmp("reset_add",   out_add, 24'h0);
      cmp("reset_sub",   out_sub, 24'h0);
    end
  endtask

  task automatic idle(int n, bit rl = 1'b0);
    for (int i = 0; i < n; i++)
      applyStimulus(rl, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom), 24'($urandom), 1'b0, 24'h0, 24'h0);
  endtask

  task automatic randOp(bit v, bit m, bit h);
    logic [23:0] uu, pp;
    if (m) begin
      uu = {1'($urandom), 23'($urandom_range(0, int'(QD) - 1))};
      pp = {1'($urandom), 23'($urandom_range(0, int'(QD) - 1))};
    end else begin
      uu = {12'($urandom_range(0, int'(QK) - 1)), 12'($urandom_range(0, int'(QK) - 1))};
      pp = {12'($urandom_range(0, int'(QK) - 1)), 12'($urandom_range(0, int'(QK) - 1))};
    end
    applyStimulus(1'b0, v, m, h, uu, pp, 1'b0, 24'h0, 24'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; half_en = 1'b0; u = '0; prod = '0;
    #1;
    rst = 1'b0;
    rst_low[0] = 1'b1;
    idle(2, 1'b1);
    idle(3);

    $display("[TB] directed Kyber, Dilithium and halving cases");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, {12'd3000, 12'd5}, {12'd500, 12'd10},
                  1'b1, {12'd171, 12'd15}, {12'd2500, 12'd3324});
    idle(LAT + 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, {1'b1, 23'd8380000}, {1'b1, 23'd1000},
                  1'b1, 24'd583, 24'd8379000);
    idle(LAT + 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, {12'd1, 12'd4}, {12'd2, 12'd2},
                  1'b1, {12'd1666, 12'd3}, {12'd1664, 12'd1});
    idle(LAT + 2);

    $display("[TB] back-to-back mixed modes");
    for (int i = 0; i < 16; i++) randOp(1'b1, 1'(i % 2), 1'($urandom));
    idle(LAT + 2);

    $display("[TB] gapped input");
    randOp(1'b1, 1'b0, 1'b0);
    randOp(1'b0, 1'b0, 1'b0);
    randOp(1'b0, 1'b1, 1'b0);
    randOp(1'b1, 1'b1, 1'b1);
    randOp(1'b1, 1'b0, 1'b1);
    idle(LAT + 3);

    $display("[TB] reset mid-operation");
    randOp(1'b1, 1'b0, 1'b0);
    randOp(1'b1, 1'b1, 1'b0);
    randOp(1'b1, 1'b0, 1'b1);
    idle(2);
    idle(2, 1'b1);
    idle(3);
    randOp(1'b1, 1'b1, 1'b1);
    idle(LAT + 3);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) randOp(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    idle(LAT + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
